// File: rtl/color_pkg.sv
// Shared color codes, target duty table and the color-to-target selector
// used by the LED driver top level.
package color_pkg;

    typedef enum logic [1:0] {
        COLOR_NATURAL = 2'b00,
        COLOR_WHITE   = 2'b01,
        COLOR_BLUE    = 2'b10,
        COLOR_ORANGE  = 2'b11
    } color_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_NATURAL = '{r: 8'd255, g: 8'd160, b: 8'd64};
    localparam rgb_t RGB_WHITE   = '{r: 8'd255, g: 8'd255, b: 8'd255};
    localparam rgb_t RGB_BLUE    = '{r: 8'd0,   g: 8'd0,   b: 8'd255};
    localparam rgb_t RGB_ORANGE  = '{r: 8'd255, g: 8'd96,  b: 8'd0};
    localparam rgb_t RGB_OFF     = '{r: 8'd0,   g: 8'd0,   b: 8'd0};

    // Target duties for a color code; a disabled light always targets black.
    function automatic rgb_t target_duty(input logic [1:0] color, input logic enable);
        rgb_t t;
        t = RGB_OFF;
        if (enable) begin
            case (color_e'(color))
                COLOR_NATURAL: t = RGB_NATURAL;
                COLOR_WHITE:   t = RGB_WHITE;
                COLOR_BLUE:    t = RGB_BLUE;
                COLOR_ORANGE:  t = RGB_ORANGE;
                default:       t = RGB_OFF;
            endcase
        end
        return t;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: duty ramps one step per fade tick toward its target,
// and the registered PWM output compares the shared counter with the duty.
module led_pwm_channel (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [7:0] target,
    input  logic [7:0] pwm_cnt,
    output logic       led,
    output logic [7:0] duty,
    output logic       differs
);

    logic [7:0] duty_next;

    // Step by one toward the target on a tick; equality check stops at target.
    always_comb begin
        duty_next = duty;
        if (tick) begin
            if (duty < target)
                duty_next = duty + 8'd1;
            else if (duty > target)
                duty_next = duty - 8'd1;
        end
    end

    // Post-update duty versus current target, registered into busy by the top.
    assign differs = (duty_next != target);

    // Duty register and PWM compare (one-cycle latency from counter to led).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty <= 8'd0;
            led  <= 1'b0;
        end else begin
            duty <= duty_next;
            led  <= (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/color_led_driver.sv
// RGB LED driver: selects target duties from the color code, fades each
// channel toward its target one step per prescaled tick, and drives PWM.
module color_led_driver
    import color_pkg::*;
#(
    parameter int FADE_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] color,
    input  logic       enable,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       busy
);

    logic [15:0] presc;
    logic [7:0]  pwm_cnt;
    logic        tick;
    rgb_t        target;
    logic        differs_r;
    logic        differs_g;
    logic        differs_b;
    logic [7:0]  duty_r;
    logic [7:0]  duty_g;
    logic [7:0]  duty_b;

    // Targets follow the inputs every cycle; nothing is latched.
    always_comb begin
        target = target_duty(color, enable);
    end

    // Tick on the prescaler wrap cycle; FADE_DIV=1 keeps presc at 0 and ticks always.
    assign tick = (presc == 16'(FADE_DIV - 1));

    // Shared prescaler and free-running PWM counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc   <= 16'd0;
            pwm_cnt <= 8'd0;
        end else begin
            presc   <= tick ? 16'd0 : presc + 16'd1;
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    // Busy reflects whether any post-update duty still differs from its target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy <= 1'b0;
        else
            busy <= differs_r | differs_g | differs_b;
    end

    led_pwm_channel u_ch_r (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .target  (target.r),
        .pwm_cnt (pwm_cnt),
        .led     (led_r),
        .duty    (duty_r),
        .differs (differs_r)
    );

    led_pwm_channel u_ch_g (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .target  (target.g),
        .pwm_cnt (pwm_cnt),
        .led     (led_g),
        .duty    (duty_g),
        .differs (differs_g)
    );

    led_pwm_channel u_ch_b (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .target  (target.b),
        .pwm_cnt (pwm_cnt),
        .led     (led_b),
        .duty    (duty_b),
        .differs (differs_b)
    );

endmodule
